// File: rtl/ysyx_22041207_seq_divider.sv
// Sequential restoring divider: one shift-subtract step per cycle on operand magnitudes,
// with sign fix-up at the end and a short path for divide-by-zero and signed overflow.
`timescale 1ns/1ps
module ysyx_22041207_seq_divider #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            flush,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            div_signed,
   output logic            in_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state, state_nxt;
   logic [6:0]      cnt;
   logic [XLEN-1:0] dvd_q;      // original dividend, needed by the divide-by-zero result
   logic [XLEN-1:0] quo_sr;     // dividend magnitude shifting out, quotient bits shifting in
   logic [XLEN-1:0] dvs_mag;
   logic [XLEN-1:0] part_rem;
   logic            neg_q, neg_r;
   logic            div_zero_q, ovf_q;

   logic            accept;
   logic [XLEN-1:0] dvd_mag_in, dvs_mag_in;
   logic [XLEN:0]   shifted, diff;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready && !flush;

   assign dvd_mag_in = (div_signed && dividend[XLEN-1]) ? -dividend : dividend;
   assign dvs_mag_in = (div_signed && divisor[XLEN-1])  ? -divisor  : divisor;

   // One restoring step: a clear borrow bit means the trial subtraction fits.
   assign shifted = {part_rem, quo_sr[XLEN-1]};
   assign diff    = shifted - {1'b0, dvs_mag};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (div_zero_q || ovf_q || cnt[6]) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // NOTE: registered state uses non-blocking assignments only; results and working
   // registers are cleared by reset because quotient/remainder must read zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         dvd_q      <= '0;
         quo_sr     <= '0;
         dvs_mag    <= '0;
         part_rem   <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         quotient   <= '0;
         remainder  <= '0;
      end else if (accept) begin
         cnt        <= '0;
         dvd_q      <= dividend;
         quo_sr     <= dvd_mag_in;
         dvs_mag    <= dvs_mag_in;
         part_rem   <= '0;
         neg_q      <= div_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
         neg_r      <= div_signed && dividend[XLEN-1];
         div_zero_q <= (divisor == '0);
         ovf_q      <= div_signed && (dividend == MIN_NEG) && (divisor == '1);
      end else if (state == BUSY && !flush) begin
         // Special cases resolve on the first busy edge; an aborted run never writes results.
         if (div_zero_q) begin
            quotient  <= '1;
            remainder <= dvd_q;
         end else if (ovf_q) begin
            quotient  <= dvd_q;
            remainder <= '0;
         end else if (cnt[6]) begin
            quotient  <= neg_q ? -quo_sr   : quo_sr;
            remainder <= neg_r ? -part_rem : part_rem;
         end else begin
            if (!diff[XLEN]) begin
               part_rem <= diff[XLEN-1:0];
               quo_sr   <= {quo_sr[XLEN-2:0], 1'b1};
            end else begin
               part_rem <= shifted[XLEN-1:0];
               quo_sr   <= {quo_sr[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + 7'd1;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041207_seq_divider.sv
// Directed and randomised checks of the sequential divider: latency, special cases,
// flush/reset aborts and a reference-model scoreboard.
`timescale 1ns/1ps
module tb_ysyx_22041207_seq_divider;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, div_signed;
   logic [63:0] dividend, divisor;
   logic        in_ready, out_valid;
   logic [63:0] quotient, remainder;

   int tests = 0;
   int fails = 0;

   localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

   ysyx_22041207_seq_divider #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
      .dividend(dividend), .divisor(divisor), .div_signed(div_signed),
      .in_ready(in_ready), .out_valid(out_valid),
      .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                 output logic [63:0] q, output logic [63:0] r, output int lat);
      if (b == 64'd0) begin
         q = ONES; r = a; lat = 1;
      end else if (s && a == MIN_NEG && b == ONES) begin
         q = a; r = 64'd0; lat = 1;
      end else if (s) begin
         q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); lat = 65;
      end else begin
         q = a / b; r = a % b; lat = 65;
      end
   endfunction

   // Accept at E0, scramble the operand inputs, then wait (bounded) for out_valid.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic hold, input string tag);
      logic [63:0] eq, er;
      int          elat, lat;
      logic        seen;
      model(a, b, s, eq, er, elat);
      check({tag, " ready_before"}, {63'd0, in_ready}, 64'd1);
      dividend = a; divisor = b; div_signed = s; in_valid = 1'b1;
      tick();
      if (!hold) in_valid = 1'b0;
      dividend = ~a; divisor = a ^ b; div_signed = ~s;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 100) begin
         tick();
         lat++;
         if (out_valid) seen = 1'b1;
      end
      in_valid = 1'b0;
      check({tag, " latency"}, 64'(lat), 64'(elat));
      check({tag, " ready_low_in_done"}, {63'd0, in_ready}, 64'd0);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      tick();
      check({tag, " idle_after"}, {62'd0, in_ready, out_valid}, 64'd2);
      check({tag, " quotient_held"}, quotient, eq);
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic        rs;
      logic        ov_seen;
      rst = 1'b1; in_valid = 1'b1; flush = 1'b1; div_signed = 1'b0;
      dividend = 64'd100; divisor = 64'd7;
      tick(); tick();
      check("reset_flags", {62'd0, in_ready, out_valid}, 64'd2);
      check("reset_quotient", quotient, 64'd0);
      check("reset_remainder", remainder, 64'd0);
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
      tick();
      check("reset_no_accept", {62'd0, in_ready, out_valid}, 64'd2);

      run_op(64'd100, 64'd7, 1'b0, 1'b0, "u_100_7");
      run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, "s_m7_2");
      run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b0, "u_m7_2");
      run_op(64'h1234, 64'd0, 1'b0, 1'b0, "u_div0");
      run_op(64'h1234, 64'd0, 1'b1, 1'b0, "s_div0");
      run_op(MIN_NEG, ONES, 1'b1, 1'b0, "s_ovf");
      run_op(MIN_NEG, ONES, 1'b0, 1'b0, "u_min_ones");
      run_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, "s_7_m2");

      // Flush at E30 of a running operation.
      dividend = 64'd1000; divisor = 64'd9; div_signed = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (29) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy_ready", {63'd0, in_ready}, 64'd1);
      ov_seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (out_valid) ov_seen = 1'b1;
      end
      check("flush_busy_no_valid", {63'd0, ov_seen}, 64'd0);
      run_op(64'd9, 64'd3, 1'b0, 1'b0, "after_flush_9_3");

      // Flush together with in_valid in IDLE accepts nothing.
      dividend = 64'd9; divisor = 64'd3; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_ready", {63'd0, in_ready}, 64'd1);
      tick();
      check("flush_idle_quiet", {62'd0, in_ready, out_valid}, 64'd2);

      // Flush arriving in DONE: the pulse already shown stands, next cycle is IDLE.
      dividend = 64'h55; divisor = 64'd0; div_signed = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("flush_done_valid", {63'd0, out_valid}, 64'd1);
      check("flush_done_quotient", quotient, ONES);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_done_idle", {62'd0, in_ready, out_valid}, 64'd2);

      // Reset at E10 of a busy operation clears results and suppresses out_valid.
      dividend = 64'd500; divisor = 64'd3; div_signed = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_busy_flags", {62'd0, in_ready, out_valid}, 64'd2);
      check("rst_busy_quotient", quotient, 64'd0);
      check("rst_busy_remainder", remainder, 64'd0);
      ov_seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (out_valid) ov_seen = 1'b1;
      end
      check("rst_busy_no_valid", {63'd0, ov_seen}, 64'd0);

      // Randomised scoreboard against the native-arithmetic model.
      for (int n = 0; n < 250; n++) begin
         ra = {$urandom, $urandom} >> $urandom_range(0, 63);
         rb = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 3) == 0) ra = -ra;
         if ($urandom_range(0, 3) == 0) rb = -rb;
         if ($urandom_range(0, 19) == 0) rb = 64'd0;
         rs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) begin
            ra = MIN_NEG; rb = ONES; rs = 1'b1;
         end
         run_op(ra, rb, rs, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
